syscall_unit: RTL and testbench

Syscall execution engine that sits directly downstream of the register file. It consumes the `v0` (service code) and `a0` (argument) register taps whenever control decode flags a SYSCALL, and stalls the core via `busy` while the service runs. For print_string it walks data memory from `a0`, one word fetch per four bytes, and streams bytes to the console over a valid/ready handshake until it reaches a NUL byte.

---
 rtl/syscall_pkg.sv | 27 ++
 rtl/syscall_byte_sel.sv | 14 +
 rtl/syscall_unit.sv | 151 +++++++++++++++
 tb/tb_syscall_unit.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/syscall_pkg.sv
// syscall_pkg: shared constants and types for the syscall execution engine.
//   - Register-file indices for v0, a0 and ra.
//   - Service codes understood by syscall_unit.
//   - FSM state encoding.
package syscall_pkg;

  // Register-file indices of the taps the engine consumes.
  localparam logic [4:0] REG_V0 = 5'd2;
  localparam logic [4:0] REG_A0 = 5'd4;
  localparam logic [4:0] REG_RA = 5'd31;

  // Service codes carried in v0.
  localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
  localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;
  localparam logic [31:0] SYS_EXIT       = 32'd10;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StEmit,
    StChar,
    StHalt,
    StDone
  } state_e;

endpackage

// File: rtl/syscall_byte_sel.sv
// syscall_byte_sel: little-endian byte-lane mux.
// Ports:
//   i_word [31:0] - memory word
//   i_off  [1:0]  - byte offset within the word (0 = bits 7:0)
//   o_byte [7:0]  - selected byte
module syscall_byte_sel (
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  output logic [7:0]  o_byte
);

  assign o_byte = i_word[{i_off, 3'b000} +: 8];

endmodule

// File: rtl/syscall_unit.sv
// syscall_unit: syscall execution engine downstream of the register file.
// Services: print_string (walks memory to NUL or MAX_LEN), print_char, exit.
// Ports:
//   i_clk, i_reset           - clock, synchronous active-high reset
//   i_syscall, i_v0, i_a0    - SYSCALL decode strobe, service code, argument
//   o_mem_rd, o_mem_addr     - word read strobe and word-aligned address
//   i_mem_rdata              - read data, valid the cycle after o_mem_rd
//   o_char_data/valid, i_char_ready - console byte stream handshake
//   o_busy                   - stall the PC/pipeline
//   o_done                   - one-cycle completion pulse
//   o_halted                 - exit taken; sticky until reset
module syscall_unit
  import syscall_pkg::*;
#(
  parameter int unsigned MAX_LEN = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_syscall,
  input  logic [31:0] i_v0,
  input  logic [31:0] i_a0,
  output logic        o_mem_rd,
  output logic [31:0] o_mem_addr,
  input  logic [31:0] i_mem_rdata,
  output logic [7:0]  o_char_data,
  output logic        o_char_valid,
  input  logic        i_char_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_halted
);

  localparam int unsigned CntW = $clog2(MAX_LEN + 1);

  state_e            r_state, w_state_next;
  logic [31:0]       r_ptr, w_ptr_next;
  logic [CntW-1:0]   r_count, w_count_next;
  logic [31:0]       r_buf;
  logic [7:0]        r_char, w_char_next;

  logic [7:0]        w_byte;
  logic [31:0]       w_ptr_inc;
  logic              w_at_limit;
  logic              w_emit_ok;

  syscall_byte_sel u_byte_sel (
    .i_word (r_buf),
    .i_off  (r_ptr[1:0]),
    .o_byte (w_byte)
  );

  assign w_ptr_inc  = r_ptr + 32'd1;
  assign w_at_limit = (r_count == CntW'(MAX_LEN));
  assign w_emit_ok  = (w_byte != 8'h00) && !w_at_limit;
  assign o_mem_addr = {r_ptr[31:2], 2'b00};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_ptr   <= '0;
      r_count <= '0;
      r_buf   <= '0;
      r_char  <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_count <= w_count_next;
      r_char  <= w_char_next;
      if (r_state == StWait) begin
        r_buf <= i_mem_rdata;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_count_next = r_count;
    w_char_next  = r_char;
    o_mem_rd     = 1'b0;
    o_char_data  = 8'h00;
    o_char_valid = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_halted     = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (i_syscall) begin
          // Combinational busy so the PC freezes in the SYSCALL cycle itself.
          o_busy      = 1'b1;
          w_char_next = i_a0[7:0];
          case (i_v0)
            SYS_PRINT_STR: begin
              w_ptr_next   = i_a0;
              w_count_next = '0;
              w_state_next = StFetch;
            end
            SYS_PRINT_CHAR: w_state_next = StChar;
            SYS_EXIT:       w_state_next = StHalt;
            default:        w_state_next = StDone;
          endcase
        end
      end
      StFetch: begin
        o_busy       = 1'b1;
        o_mem_rd     = 1'b1;
        w_state_next = StWait;
      end
      StWait: begin
        o_busy       = 1'b1;
        w_state_next = StEmit;
      end
      StEmit: begin
        o_busy = 1'b1;
        if (!w_emit_ok) begin
          w_state_next = StDone;
        end else begin
          // Valid depends only on state/buffer/count, never on ready.
          o_char_valid = 1'b1;
          o_char_data  = w_byte;
          if (i_char_ready) begin
            w_ptr_next   = w_ptr_inc;
            w_count_next = r_count + CntW'(1);
            if (w_ptr_inc[1:0] == 2'b00) begin
              w_state_next = StFetch;
            end
          end
        end
      end
      StChar: begin
        o_busy       = 1'b1;
        o_char_valid = 1'b1;
        o_char_data  = r_char;
        if (i_char_ready) begin
          w_state_next = StDone;
        end
      end
      StHalt: begin
        o_busy   = 1'b1;
        o_halted = 1'b1;
      end
      StDone: begin
        o_done       = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

endmodule

// File: tb/tb_syscall_unit.sv
module tb_syscall_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        syscall, syscall5;
  logic [31:0] v0, a0;
  logic        char_ready;
  logic [31:0] mem_rdata = '0, mem_rdata5 = '0;

  logic        mem_rd, char_valid, busy, done, halted;
  logic [31:0] mem_addr;
  logic [7:0]  char_data;
  logic        mem_rd5, char_valid5, busy5, done5, halted5;
  logic [31:0] mem_addr5;
  logic [7:0]  char_data5;

  always #5 clk = ~clk;

  syscall_unit dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_syscall    (syscall),
    .i_v0         (v0),
    .i_a0         (a0),
    .o_mem_rd     (mem_rd),
    .o_mem_addr   (mem_addr),
    .i_mem_rdata  (mem_rdata),
    .o_char_data  (char_data),
    .o_char_valid (char_valid),
    .i_char_ready (char_ready),
    .o_busy       (busy),
    .o_done       (done),
    .o_halted     (halted)
  );

  syscall_unit #(.MAX_LEN(5)) dut5 (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_syscall    (syscall5),
    .i_v0         (v0),
    .i_a0         (a0),
    .o_mem_rd     (mem_rd5),
    .o_mem_addr   (mem_addr5),
    .i_mem_rdata  (mem_rdata5),
    .o_char_data  (char_data5),
    .o_char_valid (char_valid5),
    .i_char_ready (char_ready),
    .o_busy       (busy5),
    .o_done       (done5),
    .o_halted     (halted5)
  );

  // Data memory model: one-cycle read latency.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_lookup(input logic [31:0] addr);
    if (mem.exists(addr)) return mem[addr];
    return 32'hDEAD_BEEF;
  endfunction

  always @(posedge clk) begin
    if (mem_rd)  mem_rdata  <= mem_lookup(mem_addr);
    if (mem_rd5) mem_rdata5 <= mem_lookup(mem_addr5);
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  exp_q[$];
  int          char_cyc[$];
  logic [31:0] addr_q[$];
  bit          busy_err, stable_err;
  int          valid_cycles;

  logic        s_valid, s_done, s_busy, s_memrd, s_halted;
  logic [7:0]  s_data;
  logic [31:0] s_addr;
  logic        s5_valid, s5_done;
  logic [7:0]  s5_data;

  // One clock: sample at negedge (scoreboard pop on accepted bytes), return after posedge.
  task automatic cyc();
    logic [7:0] e;
    @(negedge clk);
    s_valid  = char_valid;
    s_data   = char_data;
    s_done   = done;
    s_busy   = busy;
    s_memrd  = mem_rd;
    s_addr   = mem_addr;
    s_halted = halted;
    s5_valid = char_valid5;
    s5_data  = char_data5;
    s5_done  = done5;
    if (char_valid && char_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got byte %02h, required no byte", char_data);
      end else begin
        e = exp_q.pop_front();
        if (char_data !== e) begin
          n_fail++;
          $display("FAIL sb_byte: got %02h, required %02h", char_data, e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Drives one syscall (cycle 0) and clocks until done or the cycle limit.
  task automatic run_svc(input logic [31:0] code, input logic [31:0] arg, input int limit,
                         input int stall_from, input int stall_n, output int done_cyc);
    logic       prev_valid, prev_acc;
    logic [7:0] prev_data;
    char_cyc.delete();
    addr_q.delete();
    busy_err = 0; stable_err = 0; valid_cycles = 0; done_cyc = -1;
    prev_valid = 0; prev_acc = 0; prev_data = 0;
    for (int c = 0; c < limit; c++) begin
      syscall    = (c == 0);
      v0         = code;
      a0         = arg;
      char_ready = !(c >= stall_from && c < stall_from + stall_n);
      cyc();
      if (s_valid) begin
        valid_cycles++;
        if (prev_valid && !prev_acc && s_data !== prev_data) stable_err = 1;
        if (char_ready) char_cyc.push_back(c);
      end
      prev_valid = s_valid;
      prev_data  = s_data;
      prev_acc   = s_valid && char_ready;
      if (s_memrd) addr_q.push_back(s_addr);
      if (s_done) begin
        done_cyc = c;
        if (s_busy) busy_err = 1;
        break;
      end
      if (!s_busy) busy_err = 1;
    end
    syscall    = 0;
    char_ready = 1;
  endtask

  task automatic test_reset();
    reset = 1; syscall = 0; syscall5 = 0; v0 = 0; a0 = 0; char_ready = 1;
    cyc();
    cyc();
    n_checks++;
    if ({s_valid, s_done, s_busy, s_memrd, s_halted} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: valid/done/busy/rd/halted=%b, required 00000",
               {s_valid, s_done, s_busy, s_memrd, s_halted});
    end
    n_checks++;
    if (s_addr !== 32'h0 || s_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h data=%h, required 0/0", s_addr, s_data);
    end
    reset = 0;
    cyc();
  endtask

  task automatic test_aligned();
    int d;
    mem[32'h100] = 32'h0021_6948;
    exp_q.push_back(8'h48); exp_q.push_back(8'h69); exp_q.push_back(8'h21);
    run_svc(32'd4, 32'h100, 40, 99, 0, d);
    n_checks++;
    if (d != 7) begin n_fail++; $display("FAIL aligned_done: cycle %0d, required 7", d); end
    n_checks++;
    if (char_cyc.size() != 3 || char_cyc[0] != 3 || char_cyc[1] != 4 || char_cyc[2] != 5) begin
      n_fail++;
      $display("FAIL aligned_byte_cycles: %0d bytes, required bytes in cycles 3,4,5",
               char_cyc.size());
    end
    n_checks++;
    if (busy_err) begin n_fail++; $display("FAIL aligned_busy: got glitch, required busy 0-6"); end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL aligned_missing: %0d left, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_unaligned();
    int d;
    mem[32'h100] = 32'h4100_0000;
    mem[32'h104] = 32'h0000_0042;
    exp_q.push_back(8'h41); exp_q.push_back(8'h42);
    run_svc(32'd4, 32'h103, 40, 99, 0, d);
    n_checks++;
    if (d != 8) begin n_fail++; $display("FAIL unaligned_done: cycle %0d, required 8", d); end
    n_checks++;
    if (addr_q.size() != 2 || addr_q[0] !== 32'h100 || addr_q[1] !== 32'h104) begin
      n_fail++;
      $display("FAIL unaligned_addr: %0d fetches first %h, required 0x100,0x104",
               addr_q.size(), addr_q.size() > 0 ? addr_q[0] : 32'h0);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL unaligned_missing: %0d left, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    int d;
    exp_q.push_back(8'h5A);
    run_svc(32'd11, 32'h0000_005A, 20, 1, 3, d);
    n_checks++;
    if (d != 5) begin n_fail++; $display("FAIL bp_done: cycle %0d, required 5", d); end
    n_checks++;
    if (valid_cycles != 4 || stable_err) begin
      n_fail++;
      $display("FAIL bp_hold: valid %0d cycles unstable=%0d, required 4/0", valid_cycles,
               stable_err);
    end
    n_checks++;
    if (char_cyc.size() != 1 || char_cyc[0] != 4) begin
      n_fail++; $display("FAIL bp_accept: %0d accepts, required 1 in cycle 4", char_cyc.size());
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    exp_q.push_back(8'h78);
    run_svc(32'd11, 32'h0000_0078, 10, 99, 0, d1);
    exp_q.push_back(8'h00);  // NUL is a legal print_char byte
    run_svc(32'd11, 32'hFFFF_FF00, 10, 99, 0, d2);
    n_checks++;
    if (d1 != 2 || d2 != 2) begin
      n_fail++; $display("FAIL b2b_done: cycles %0d,%0d, required 2,2", d1, d2);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_missing: %0d left, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_noop();
    int d;
    run_svc(32'd7, 32'h100, 10, 99, 0, d);
    n_checks++;
    if (d != 1 || valid_cycles != 0) begin
      n_fail++;
      $display("FAIL noop: done cycle %0d valid %0d, required 1/0", d, valid_cycles);
    end
  endtask

  task automatic test_exit();
    int  d;
    bit  bad;
    run_svc(32'd10, 32'h0, 1, 99, 0, d);
    bad = 0;
    for (int c = 1; c < 8; c++) begin
      syscall = (c == 3);
      v0 = 32'd4; a0 = 32'h100;
      cyc();
      if (!s_halted || !s_busy || s_done || s_memrd || s_valid) bad = 1;
    end
    syscall = 0;
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL exit_sticky: halted=%b busy=%b, required halted/busy held, no activity",
               s_halted, s_busy);
    end
    reset = 1;
    cyc();
    reset = 0;
    cyc();
    n_checks++;
    if (s_halted !== 1'b0 || s_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL exit_reset: halted=%b busy=%b, required 0/0", s_halted, s_busy);
    end
  endtask

  task automatic test_truncation();
    logic [7:0] got[$];
    int         d;
    bit         bytes_ok;
    logic [7:0] want;
    mem[32'h200] = 32'h6463_6261;
    mem[32'h204] = 32'h6867_6665;
    mem[32'h208] = 32'h6C6B_6A69;
    mem[32'h20C] = 32'h0000_0000;
    d = -1;
    char_ready = 1;
    for (int c = 0; c < 40; c++) begin
      syscall5 = (c == 0);
      v0 = 32'd4; a0 = 32'h200;
      cyc();
      if (s5_valid) got.push_back(s5_data);
      if (s5_done) begin d = c; break; end
    end
    syscall5 = 0;
    bytes_ok = (got.size() == 5);
    for (int i = 0; i < got.size() && i < 5; i++) begin
      want = 8'h61 + 8'(i);
      if (got[i] !== want) bytes_ok = 0;
    end
    n_checks++;
    if (!bytes_ok) begin
      n_fail++; $display("FAIL trunc_bytes: %0d bytes, required 5 bytes 61..65", got.size());
    end
    n_checks++;
    if (d != 11) begin n_fail++; $display("FAIL trunc_done: cycle %0d, required 11", d); end
  endtask

  task automatic test_reset_mid_emit();
    bit bad;
    exp_q.push_back(8'h61);
    for (int c = 0; c < 4; c++) begin
      syscall = (c == 0);
      v0 = 32'd4; a0 = 32'h200; char_ready = 1;
      cyc();
    end
    syscall = 0;
    reset = 1; char_ready = 0;
    cyc();
    reset = 0; char_ready = 1;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      if (s_valid || s_done || s_busy || s_memrd) bad = 1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL reset_abort: valid=%b done=%b busy=%b, required all 0 after reset",
               s_valid, s_done, s_busy);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL reset_abort_first: %0d left, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    #1;
    test_reset();
    test_aligned();
    test_unaligned();
    test_backpressure();
    test_back_to_back();
    test_noop();
    test_exit();
    test_truncation();
    test_reset_mid_emit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
